snow64_param_instr_cache: RTL and testbench

//  Parametrised N-set, 1- or 2-way set-associative read-only instruction cache.

---
 rtl/snow64_param_instr_cache.sv | 171 +++++++++++++++++
 tb/tb_snow64_param_instr_cache.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_param_instr_cache.sv
// Parametrised read-only instruction cache: N sets, 1 or 2 ways, per-set LRU,
// multi-cycle flush, single-cycle hit path and wrapping hit/miss counters.
module snow64_param_instr_cache #(
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned LINE_WIDTH    = 256,
  parameter int unsigned NUM_SETS      = 64,
  parameter int unsigned NUM_WAYS      = 2,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_rd_req,
  input  logic [ADDR_WIDTH-1:0]    in_rd_addr,
  input  logic                     in_flush,
  output logic                     out_rd_busy,
  output logic                     out_rd_valid,
  output logic [LINE_WIDTH-1:0]    out_rd_data,
  output logic                     out_mem_req,
  output logic [ADDR_WIDTH-1:0]    out_mem_addr,
  input  logic                     in_mem_valid,
  input  logic [LINE_WIDTH-1:0]    in_mem_data,
  output logic [COUNTER_WIDTH-1:0] out_hit_cnt,
  output logic [COUNTER_WIDTH-1:0] out_miss_cnt
);

  localparam int unsigned OffW = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IdxW = $clog2(NUM_SETS);
  localparam int unsigned TagW = ADDR_WIDTH - OffW - IdxW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0] state;
  logic [1:0] nextState;

  logic [NUM_WAYS-1:0]   validArr [NUM_SETS];
  logic [NUM_SETS-1:0]   lruArr;
  logic [TagW-1:0]       tagArr   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] lineArr  [NUM_SETS][NUM_WAYS];

  logic            flushPending;
  logic [IdxW-1:0] flushCnt;
  logic            fillWay;

  logic [TagW-1:0]       reqTag;
  logic [IdxW-1:0]       reqIdx;
  logic [TagW-1:0]       fillTag;
  logic [IdxW-1:0]       fillIdx;
  logic                  hitAny;
  logic                  hitWay;
  logic [LINE_WIDTH-1:0] hitLine;
  logic                  victimWay;
  logic                  accept;
  logic                  lookupHit;
  logic                  lookupMiss;
  logic                  fillDone;
  logic                  unusedAddrBits;

  assign reqTag         = in_rd_addr[ADDR_WIDTH-1 -: TagW];
  assign reqIdx         = in_rd_addr[OffW +: IdxW];
  assign unusedAddrBits = ^in_rd_addr[OffW-1:0];
  // The in-flight fill address doubles as the latched tag/index of the miss
  assign fillTag        = out_mem_addr[ADDR_WIDTH-1 -: TagW];
  assign fillIdx        = out_mem_addr[OffW +: IdxW];

  assign out_rd_busy = (state != StIdle) | in_flush;
  assign accept      = in_rd_req & ~out_rd_busy;
  assign lookupHit   = accept & hitAny;
  assign lookupMiss  = accept & ~hitAny;
  assign fillDone    = (state == StFill) & in_mem_valid;

  // Tag lookup and victim choice for the requested set
  always_comb begin
    hitAny    = 1'b0;
    hitWay    = 1'b0;
    hitLine   = '0;
    victimWay = (NUM_WAYS == 1) ? 1'b0 : lruArr[reqIdx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!validArr[reqIdx][w]) victimWay = 1'(w);
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (validArr[reqIdx][w] && (tagArr[reqIdx][w] == reqTag)) begin
        hitAny  = 1'b1;
        hitWay  = 1'(w);
        hitLine = lineArr[reqIdx][w];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= StIdle;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      StIdle: begin
        if (in_flush)        nextState = StFlush;
        else if (lookupMiss) nextState = StFill;
      end
      StFill: begin
        if (in_mem_valid) nextState = (flushPending | in_flush) ? StFlush : StIdle;
      end
      StFlush: begin
        if (flushCnt == IdxW'(NUM_SETS - 1)) nextState = StIdle;
      end
      default: nextState = StIdle;
    endcase
  end

  // Control state, valid/LRU bits, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) validArr[s] <= '0;
      lruArr       <= '0;
      flushPending <= 1'b0;
      flushCnt     <= '0;
      fillWay      <= 1'b0;
      out_rd_valid <= 1'b0;
      out_rd_data  <= '0;
      out_mem_req  <= 1'b0;
      out_mem_addr <= '0;
      out_hit_cnt  <= '0;
      out_miss_cnt <= '0;
    end else begin
      out_rd_valid <= 1'b0;
      if (lookupHit) begin
        out_rd_valid   <= 1'b1;
        out_rd_data    <= hitLine;
        lruArr[reqIdx] <= ~hitWay;
        out_hit_cnt    <= out_hit_cnt + COUNTER_WIDTH'(1);
      end
      if (lookupMiss) begin
        out_miss_cnt <= out_miss_cnt + COUNTER_WIDTH'(1);
        out_mem_req  <= 1'b1;
        out_mem_addr <= {reqTag, reqIdx, OffW'(0)};
        fillWay      <= victimWay;
      end
      if (state == StFill) begin
        if (in_mem_valid) begin
          validArr[fillIdx][fillWay] <= 1'b1;
          lruArr[fillIdx]            <= ~fillWay;
          out_mem_req                <= 1'b0;
          out_rd_valid               <= 1'b1;
          out_rd_data                <= in_mem_data;
          flushPending               <= 1'b0;
        end else if (in_flush) begin
          flushPending <= 1'b1;
        end
      end
      if (state == StFlush) begin
        validArr[flushCnt] <= '0;
        lruArr[flushCnt]   <= 1'b0;
        flushCnt           <= flushCnt + IdxW'(1);
      end
    end
  end

  // Tag and line storage, written only when a fill returns
  always_ff @(posedge clk) begin
    if (fillDone) begin
      tagArr[fillIdx][fillWay]  <= fillTag;
      lineArr[fillIdx][fillWay] <= in_mem_data;
    end
  end

endmodule

// File: tb/tb_snow64_param_instr_cache.sv
// Self-checking bench for snow64_param_instr_cache (2-way, 64 sets, 32B lines, 4-bit counters).
module tb_snow64_param_instr_cache;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 256;
  localparam int unsigned NS = 64;
  localparam int unsigned NW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned OFFB = 5;
  localparam int unsigned IDXB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_rd_req;
  logic [AW-1:0] in_rd_addr;
  logic          in_flush;
  logic          out_rd_busy;
  logic          out_rd_valid;
  logic [LW-1:0] out_rd_data;
  logic          out_mem_req;
  logic [AW-1:0] out_mem_addr;
  logic          in_mem_valid;
  logic [LW-1:0] in_mem_data;
  logic [CW-1:0] out_hit_cnt;
  logic [CW-1:0] out_miss_cnt;

  int errors = 0;
  int checks = 0;

  snow64_param_instr_cache #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .NUM_SETS(NS), .NUM_WAYS(NW), .COUNTER_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_rd_req(in_rd_req), .in_rd_addr(in_rd_addr), .in_flush(in_flush),
    .out_rd_busy(out_rd_busy), .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data),
    .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr), .in_mem_valid(in_mem_valid),
    .in_mem_data(in_mem_data), .out_hit_cnt(out_hit_cnt), .out_miss_cnt(out_miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each set holds up to NW lines; the replaced line is an
  // empty slot (lowest first) or else the one least recently touched.
  bit            mValid [NS][NW];
  logic [AW-1:0] mTag   [NS][NW];
  logic [LW-1:0] mData  [NS][NW];
  int            mStamp [NS][NW];
  int            stampNow = 0;
  int            mHits = 0;
  int            mMisses = 0;

  function automatic void modelFlush();
    for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) mValid[s][w] = 1'b0;
  endfunction

  function automatic void modelReset();
    modelFlush();
    mHits = 0;
    mMisses = 0;
  endfunction

  function automatic void modelAccess(input logic [AW-1:0] addr, input logic [LW-1:0] fill,
                                      output bit hit, output logic [LW-1:0] data);
    int s = int'((addr / (AW'(1) << OFFB)) % NS);
    logic [AW-1:0] t = addr >> (OFFB + IDXB);
    int v = -1;
    hit = 1'b0;
    data = '0;
    stampNow++;
    for (int w = 0; w < NW; w++) begin
      if (mValid[s][w] && mTag[s][w] == t) begin
        hit = 1'b1;
        data = mData[s][w];
        mStamp[s][w] = stampNow;
      end
    end
    if (hit) begin
      mHits++;
    end else begin
      for (int w = 0; w < NW; w++) if (v < 0 && !mValid[s][w]) v = w;
      if (v < 0) v = (mStamp[s][0] < mStamp[s][1]) ? 0 : 1;
      mValid[s][v] = 1'b1;
      mTag[s][v] = t;
      mData[s][v] = fill;
      mStamp[s][v] = stampNow;
      data = fill;
      mMisses++;
    end
  endfunction

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] d;
    for (int k = 0; k < LW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Issues one read; on a miss, answers the fill after lat idle cycles.
  task automatic readLine(input logic [AW-1:0] addr, input int lat, input logic [LW-1:0] fill,
                          output bit gotValid, output logic [LW-1:0] gotData, output bit missed,
                          output logic [AW-1:0] memAddr, output bit reqAfter);
    @(negedge clk);
    in_rd_req = 1'b1;
    in_rd_addr = addr;
    @(negedge clk);
    in_rd_req = 1'b0;
    gotValid = out_rd_valid;
    gotData = out_rd_data;
    missed = out_mem_req;
    memAddr = out_mem_addr;
    reqAfter = 1'b0;
    if (missed) begin
      repeat (lat) @(negedge clk);
      in_mem_valid = 1'b1;
      in_mem_data = fill;
      @(negedge clk);
      in_mem_valid = 1'b0;
      gotValid = out_rd_valid;
      gotData = out_rd_data;
      reqAfter = out_mem_req;
    end
  endtask

  logic [LW-1:0] lineD;

  task automatic test_reset();
    rst = 1'b1; in_rd_req = 1'b0; in_rd_addr = '0; in_flush = 1'b0;
    in_mem_valid = 1'b0; in_mem_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checks++;
    if (out_rd_valid !== 1'b0 || out_mem_req !== 1'b0 || out_rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b memreq=%b busy=%b required 0 0 0", out_rd_valid, out_mem_req, out_rd_busy);
    end
    checks++;
    if (out_mem_addr !== '0 || out_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: memaddr=%h data=%h required zero", out_mem_addr, out_rd_data);
    end
    checks++;
    if (out_hit_cnt !== '0 || out_miss_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d required 0 0", out_hit_cnt, out_miss_cnt);
    end
  endtask

  task automatic test_cold_miss();
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed;
    logic [AW-1:0] ma;
    lineD = randLine();
    modelAccess(64'h1000, lineD, eh, ed);
    readLine(64'h1000, 3, lineD, v, d, m, ma, ra);
    checks++;
    if (m !== 1'b1 || ma !== 64'h1000) begin
      errors++;
      $display("FAIL cold_miss_req: memreq=%b addr=%h required 1 0x1000", m, ma);
    end
    checks++;
    if (v !== 1'b1 || d !== lineD) begin
      errors++;
      $display("FAIL cold_miss_data: valid=%b data=%h required 1 %h", v, d, lineD);
    end
    checks++;
    if (out_miss_cnt !== CW'(1) || ra !== 1'b0) begin
      errors++;
      $display("FAIL cold_miss_cnt: miss=%0d memreq_after=%b required 1 0", out_miss_cnt, ra);
    end
  endtask

  task automatic test_hit_pipeline();
    bit v1, v2, r1, r2, eh;
    logic [LW-1:0] d1, d2, ed;
    @(negedge clk);
    in_rd_req = 1'b1; in_rd_addr = 64'h1008;
    @(negedge clk);
    in_rd_addr = 64'h1010;
    v1 = out_rd_valid; d1 = out_rd_data; r1 = out_mem_req;
    @(negedge clk);
    in_rd_req = 1'b0;
    v2 = out_rd_valid; d2 = out_rd_data; r2 = out_mem_req;
    modelAccess(64'h1008, '0, eh, ed);
    modelAccess(64'h1010, '0, eh, ed);
    checks++;
    if (v1 !== 1'b1 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL pipe_valid: valid=%b,%b required 1,1", v1, v2);
    end
    checks++;
    if (d1 !== lineD || d2 !== lineD) begin
      errors++;
      $display("FAIL pipe_data: data0=%h data1=%h required %h", d1, d2, lineD);
    end
    checks++;
    if (out_hit_cnt !== CW'(2) || r1 !== 1'b0 || r2 !== 1'b0) begin
      errors++;
      $display("FAIL pipe_cnt: hit=%0d memreq=%b,%b required 2 0,0", out_hit_cnt, r1, r2);
    end
  endtask

  task automatic test_lru();
    logic [AW-1:0] seq [6] = '{64'h0000, 64'h0800, 64'h0000, 64'h1000, 64'h0000, 64'h0800};
    bit expMiss [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma;
    resetDut();
    for (int i = 0; i < 6; i++) begin
      f = randLine();
      modelAccess(seq[i], f, eh, ed);
      readLine(seq[i], 1, f, v, d, m, ma, ra);
      checks++;
      if (m !== expMiss[i] || eh === expMiss[i] || v !== 1'b1 || d !== ed) begin
        errors++;
        $display("FAIL lru_step%0d: miss=%b valid=%b data=%h required miss=%b valid=1 data=%h",
                 i, m, v, d, expMiss[i], ed);
      end
    end
  endtask

  task automatic test_flush_idle();
    int cnt = 0;
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma;
    @(negedge clk);
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    while (out_rd_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    modelFlush();
    checks++;
    if (cnt != NS) begin
      errors++;
      $display("FAIL flush_busy_len: busy cycles=%0d required %0d", cnt, NS);
    end
    f = randLine();
    modelAccess(64'h0000, f, eh, ed);
    readLine(64'h0000, 2, f, v, d, m, ma, ra);
    checks++;
    if (m !== 1'b1 || v !== 1'b1 || d !== f) begin
      errors++;
      $display("FAIL flush_then_miss: miss=%b valid=%b data=%h required 1 1 %h", m, v, d, f);
    end
  endtask

  task automatic test_flush_fill();
    int cnt = 0;
    bit eh, v, m, ra;
    logic [LW-1:0] f, ed, d;
    logic [AW-1:0] ma;
    f = randLine();
    @(negedge clk);
    in_rd_req = 1'b1; in_rd_addr = 64'h2040;
    @(negedge clk);
    in_rd_req = 1'b0;
    checks++;
    if (out_mem_req !== 1'b1) begin
      errors++;
      $display("FAIL flushfill_req: memreq=%b required 1", out_mem_req);
    end
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    @(negedge clk);
    in_mem_valid = 1'b1; in_mem_data = f;
    @(negedge clk);
    in_mem_valid = 1'b0;
    checks++;
    if (out_rd_valid !== 1'b1 || out_rd_data !== f) begin
      errors++;
      $display("FAIL flushfill_data: valid=%b data=%h required 1 %h", out_rd_valid, out_rd_data, f);
    end
    while (out_rd_busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    modelAccess(64'h2040, f, eh, ed);
    modelFlush();
    checks++;
    if (cnt != NS) begin
      errors++;
      $display("FAIL flushfill_busy_len: busy cycles=%0d required %0d", cnt, NS);
    end
    f = randLine();
    modelAccess(64'h2040, f, eh, ed);
    readLine(64'h2040, 0, f, v, d, m, ma, ra);
    checks++;
    if (m !== 1'b1 || v !== 1'b1 || d !== f) begin
      errors++;
      $display("FAIL flushfill_remiss: miss=%b valid=%b required 1 1", m, v);
    end
  endtask

  task automatic test_simultaneous();
    int cnt = 0;
    bit sawValid = 1'b0;
    @(negedge clk);
    in_flush = 1'b1; in_rd_req = 1'b1; in_rd_addr = 64'h2040;
    @(negedge clk);
    in_flush = 1'b0; in_rd_req = 1'b0;
    while (out_rd_busy && cnt < 200) begin
      if (out_rd_valid) sawValid = 1'b1;
      cnt++;
      @(negedge clk);
    end
    if (out_rd_valid) sawValid = 1'b1;
    modelFlush();
    checks++;
    if (sawValid || out_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL simul_no_read: valid_seen=%b memreq=%b required 0 0", sawValid, out_mem_req);
    end
    checks++;
    if (out_hit_cnt !== CW'(mHits) || out_miss_cnt !== CW'(mMisses) || cnt != NS) begin
      errors++;
      $display("FAIL simul_cnt: hit=%0d miss=%0d busy=%0d required %0d %0d %0d",
               out_hit_cnt, out_miss_cnt, cnt, CW'(mHits), CW'(mMisses), NS);
    end
  endtask

  task automatic test_stray();
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma;
    f = randLine();
    modelAccess(64'h3060, f, eh, ed);
    readLine(64'h3060, 1, f, v, d, m, ma, ra);
    @(negedge clk);
    in_mem_valid = 1'b1; in_mem_data = randLine();
    @(negedge clk);
    in_mem_valid = 1'b0;
    checks++;
    if (out_rd_valid !== 1'b0 || out_mem_req !== 1'b0 || out_rd_busy !== 1'b0 ||
        out_hit_cnt !== CW'(mHits) || out_miss_cnt !== CW'(mMisses)) begin
      errors++;
      $display("FAIL stray_ignored: valid=%b memreq=%b busy=%b hit=%0d miss=%0d",
               out_rd_valid, out_mem_req, out_rd_busy, out_hit_cnt, out_miss_cnt);
    end
    modelAccess(64'h3060, '0, eh, ed);
    readLine(64'h3060, 1, randLine(), v, d, m, ma, ra);
    checks++;
    if (m !== 1'b0 || v !== 1'b1 || d !== ed) begin
      errors++;
      $display("FAIL stray_line_kept: miss=%b valid=%b data=%h required 0 1 %h", m, v, d, ed);
    end
  endtask

  task automatic test_reset_fill();
    bit sawValid = 1'b0;
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma;
    @(negedge clk);
    in_rd_req = 1'b1; in_rd_addr = 64'h3060;
    @(negedge clk);
    in_rd_req = 1'b1; in_rd_addr = 64'h4000;
    @(negedge clk);
    in_rd_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_mem_req !== 1'b0 || out_miss_cnt !== '0 || out_hit_cnt !== '0) begin
      errors++;
      $display("FAIL rstfill_clear: memreq=%b hit=%0d miss=%0d required 0 0 0", out_mem_req, out_hit_cnt, out_miss_cnt);
    end
    rst = 1'b0;
    modelReset();
    repeat (3) begin
      @(negedge clk);
      if (out_rd_valid) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("FAIL rstfill_no_valid: valid seen=1 required 0");
    end
    f = randLine();
    modelAccess(64'h4000, f, eh, ed);
    readLine(64'h4000, 1, f, v, d, m, ma, ra);
    checks++;
    if (m !== 1'b1 || v !== 1'b1 || d !== f || out_miss_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL rstfill_remiss: miss=%b valid=%b misscnt=%0d required 1 1 1", m, v, out_miss_cnt);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma;
    resetDut();
    f = randLine();
    modelAccess(64'h5000, f, eh, ed);
    readLine(64'h5000, 0, f, v, d, m, ma, ra);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (out_rd_valid) pulses++;
      in_rd_req = 1'b1;
      in_rd_addr = 64'h5000 + AW'(i % 32);
      modelAccess(in_rd_addr, '0, eh, ed);
    end
    @(negedge clk);
    in_rd_req = 1'b0;
    if (out_rd_valid) pulses++;
    checks++;
    if (out_hit_cnt !== CW'(1) || out_hit_cnt !== CW'(mHits)) begin
      errors++;
      $display("FAIL wrap_hitcnt: hit=%0d required 1", out_hit_cnt);
    end
    checks++;
    if (pulses != 17) begin
      errors++;
      $display("FAIL wrap_pulses: valid pulses=%0d required 17", pulses);
    end
  endtask

  task automatic test_random();
    bit v, m, ra, eh;
    logic [LW-1:0] d, ed, f;
    logic [AW-1:0] ma, a;
    resetDut();
    for (int i = 0; i < 80; i++) begin
      a = (AW'($urandom_range(0, 3)) << 11) | (AW'($urandom_range(0, 3)) << 5) | AW'($urandom_range(0, 31));
      f = randLine();
      modelAccess(a, f, eh, ed);
      readLine(a, int'($urandom_range(0, 4)), f, v, d, m, ma, ra);
      checks++;
      if (m !== !eh || v !== 1'b1 || d !== ed || (m && ma !== (a & ~AW'(31)))) begin
        errors++;
        $display("FAIL rand_%0d addr=%h: miss=%b valid=%b memaddr=%h required miss=%b valid=1 memaddr=%h data_ok=%b",
                 i, a, m, v, ma, !eh, a & ~AW'(31), d === ed);
      end
    end
    checks++;
    if (out_hit_cnt !== CW'(mHits) || out_miss_cnt !== CW'(mMisses)) begin
      errors++;
      $display("FAIL rand_counters: hit=%0d miss=%0d required %0d %0d", out_hit_cnt, out_miss_cnt, CW'(mHits), CW'(mMisses));
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_pipeline();
    test_lru();
    test_flush_idle();
    test_flush_fill();
    test_simultaneous();
    test_stray();
    test_reset_fill();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
